elevator_call_latch: RTL

//  Upstream stage of the 4-floor elevator FSM. Captures momentary floor-call buttons as sticky

---
 rtl/elevator_pkg.sv | 15 +
 rtl/btn_edge_det.sv | 41 ++++
 rtl/elevator_call_latch.sv | 85 ++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared floor codes and door state encoding for the elevator call path and the elevator FSM.
package elevator_pkg;
  localparam int NFLOOR = 4;

  localparam logic [1:0] FLR_A = 2'd0;
  localparam logic [1:0] FLR_B = 2'd1;
  localparam logic [1:0] FLR_C = 2'd2;
  localparam logic [1:0] FLR_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } door_state_t;
endpackage

// File: rtl/btn_edge_det.sv
// Rising-edge detector for the call buttons. ELEV_BTN_SYNC_EN adds a 2-flop synchronizer
// ahead of the detector for asynchronous button inputs.
module btn_edge_det
  import elevator_pkg::*;
#(
  parameter int W = NFLOOR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn,
  output logic [W-1:0] btn_rise
);
  logic [W-1:0] btn_s;
  logic [W-1:0] btn_q;

`ifdef ELEV_BTN_SYNC_EN
  logic [W-1:0] sync1;
  logic [W-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign btn_s = sync2;
`else
  assign btn_s = btn;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= '0;
    else        btn_q <= btn_s;
  end

  assign btn_rise = btn_s & ~btn_q;
endmodule

// File: rtl/elevator_call_latch.sv
// Latches floor calls as sticky requests for the elevator FSM and runs the door dwell at the
// served floor. Build option ELEV_BTN_SYNC_EN synchronizes the buttons (see btn_edge_det).
module elevator_call_latch
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic [1:0] floor,
  output logic [3:0] req,
  output logic       door_open,
  output logic       busy
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

  door_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [NFLOOR-1:0] pending;
  logic [NFLOOR-1:0] pending_nx;
  logic [NFLOOR-1:0] clr;
  logic [NFLOOR-1:0] rise;
  logic [1:0]        floor_q;
  logic              stable;
  logic              open_go;

  btn_edge_det #(.W(NFLOOR)) u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .btn_rise (rise)
  );

  assign stable  = (floor == floor_q);
  assign open_go = (state == IDLE) && pending[floor] && stable;

  // A dwell that expires normally retires its floor; a rise on the same edge re-arms it.
  always_comb begin
    clr = '0;
    if (state == OPEN && stable && cnt == '0) clr[floor_q] = 1'b1;
    pending_nx = (pending & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= '0;
      floor_q   <= FLR_A;
      door_open <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pending <= pending_nx;
      floor_q <= floor;
      // OPEN always leaves to OPEN or CLOSE, so it is busy next cycle either way.
      busy    <= (|pending_nx) || open_go || (state == OPEN);
      case (state)
        IDLE: if (open_go) begin
          state     <= OPEN;
          cnt       <= CNT_LOAD;
          door_open <= 1'b1;
        end
        OPEN: begin
          if (!stable || cnt == '0) begin
            state     <= CLOSE;
            door_open <= 1'b0;
          end else if (rise[floor_q]) begin
            cnt <= CNT_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CLOSE: state <= IDLE;
        default: begin
          state     <= IDLE;
          door_open <= 1'b0;
        end
      endcase
    end
  end

  assign req = pending;
endmodule
